// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   Branch decode/resolve in ID plus a direct-mapped table of 2-bit
//   saturating counters read by IF for a taken/not-taken prediction.
//   Mispredicts raise a one-cycle redirect request with the correct next PC.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   if_pc               fetch PC used for the table lookup
//   if_pred_taken       prediction for if_pc (0-cycle lookup)
//   id_valid, id_stall  ID slot qualifiers
//   id_opcode/rt/imm    instruction fields of the ID instruction
//   id_pc               PC of the ID instruction
//   id_rs_data/rt_data  forwarded operands
//   id_pred_taken       prediction carried through IF/ID
//   id_is_branch, id_taken, id_mispredict, id_redirect_pc  resolve results
//   perf_branches, perf_mispredicts  saturating event counters
//
// Optional feature: define BRANCH_PERF_EN to build the performance counters;
// otherwise both perf ports are tied to 0 and no counter flops exist.
module branch_predict_unit #(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] if_pc,
  output logic             if_pred_taken,
  input  logic             id_valid,
  input  logic             id_stall,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rt,
  input  logic [15:0]      id_imm,
  input  logic [WIDTH-1:0] id_pc,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic             id_pred_taken,
  output logic             id_is_branch,
  output logic             id_taken,
  output logic             id_mispredict,
  output logic [WIDTH-1:0] id_redirect_pc,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_mispredicts
);

  localparam int IDX = $clog2(BHT_DEPTH);

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;

  // pc + 4 + (sign_extend(imm) << 2), wrapping modulo 2^WIDTH
  function automatic logic [WIDTH-1:0] branch_target(input logic [WIDTH-1:0] pc,
                                                      input logic [15:0]      imm);
    logic signed [WIDTH-1:0] off;
    off = {{(WIDTH-18){imm[15]}}, imm, 2'b00};
    return pc + WIDTH'(4) + off;
  endfunction

  function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken && cnt != 2'b11)
      res = cnt + 2'd1;
    else if (!taken && cnt != 2'b00)
      res = cnt - 2'd1;
    return res;
  endfunction

  logic [1:0]     bht_q [BHT_DEPTH];
  logic [1:0]     bht_d;
  logic [IDX-1:0] if_idx;
  logic [IDX-1:0] id_idx;
  logic           bht_we;

  logic signed [WIDTH-1:0] rs_s;
  logic is_bltz, is_bgez, is_beq, is_bne, cond;
  logic unused_ok;

  // Only the index bits of if_pc are needed for the lookup.
  assign unused_ok = ^if_pc;

  // ---- ID decode / resolve (combinational)
  always_comb begin
    rs_s    = id_rs_data;
    is_bltz = (id_opcode == OP_REGIMM) && (id_rt == 5'b00000);
    is_bgez = (id_opcode == OP_REGIMM) && (id_rt == 5'b00001);
    is_beq  = (id_opcode == OP_BEQ);
    is_bne  = (id_opcode == OP_BNE);
    cond    = (is_bltz && (rs_s < 0)) ||
              (is_bgez && !(rs_s < 0)) ||
              (is_beq  && (id_rs_data == id_rt_data)) ||
              (is_bne  && (id_rs_data != id_rt_data));
    id_is_branch   = id_valid && (is_bltz || is_bgez || is_beq || is_bne);
    id_taken       = id_is_branch && cond;
    id_redirect_pc = id_taken ? branch_target(id_pc, id_imm) : id_pc + WIDTH'(4);
    // A predicted-taken non-branch (aliasing) also mispredicts.
    id_mispredict  = id_valid && !id_stall && (id_taken != id_pred_taken);
  end

  // ---- IF lookup (combinational, no bypass of a same-cycle update)
  assign if_idx        = if_pc[IDX+1:2];
  assign if_pred_taken = !reset && bht_q[if_idx][1];

  // ---- table update
  assign id_idx = id_pc[IDX+1:2];
  assign bht_we = id_is_branch && !id_stall;
  assign bht_d  = cnt_update(bht_q[id_idx], id_taken);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++)
        bht_q[i] <= 2'b01;
    end else if (bht_we) begin
      bht_q[id_idx] <= bht_d;
    end
  end

`ifdef BRANCH_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] perf_br_q, perf_br_d;
  logic [CNT_W-1:0] perf_mp_q, perf_mp_d;

  always_comb begin
    perf_br_d = bht_we        ? sat_inc(perf_br_q) : perf_br_q;
    perf_mp_d = id_mispredict ? sat_inc(perf_mp_q) : perf_mp_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      perf_br_q <= perf_br_d;
      perf_mp_q <= perf_mp_d;
    end
  end

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mp_q;
`else
  assign perf_branches    = '0;
  assign perf_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

  localparam int WIDTH = 32;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] if_pc;
  logic             if_pred_taken;
  logic             id_valid, id_stall;
  logic [5:0]       id_opcode;
  logic [4:0]       id_rt;
  logic [15:0]      id_imm;
  logic [WIDTH-1:0] id_pc, id_rs_data, id_rt_data;
  logic             id_pred_taken;
  logic             id_is_branch, id_taken, id_mispredict;
  logic [WIDTH-1:0] id_redirect_pc;
  logic [CNT_W-1:0] perf_branches, perf_mispredicts;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_predict_unit #(.WIDTH(WIDTH), .BHT_DEPTH(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .id_valid(id_valid), .id_stall(id_stall), .id_opcode(id_opcode), .id_rt(id_rt),
    .id_imm(id_imm), .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_pred_taken(id_pred_taken), .id_is_branch(id_is_branch), .id_taken(id_taken),
    .id_mispredict(id_mispredict), .id_redirect_pc(id_redirect_pc),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic [31:0] pc;
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic        pred;
    logic        valid;
    logic        stall;
    logic        e_br;
    logic        e_tk;
    logic        e_mp;
    logic [31:0] e_redir;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive ID inputs just after a falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm,
                       input logic [31:0] pc, input logic [31:0] rs_d, input logic [31:0] rt_d,
                       input logic pred, input logic valid, input logic stall);
    @(negedge clk);
    id_opcode = op; id_rt = rt; id_imm = imm; id_pc = pc;
    id_rs_data = rs_d; id_rt_data = rt_d; id_pred_taken = pred;
    id_valid = valid; id_stall = stall;
    #1;
  endtask

  task automatic idle();
    drive(6'd0, 5'd0, 16'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; id_valid = 1'b0; id_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t vecs[12];

  initial begin
    reset = 1'b1; if_pc = '0; id_valid = 0; id_stall = 0; id_opcode = 0; id_rt = 0;
    id_imm = 0; id_pc = 0; id_rs_data = 0; id_rt_data = 0; id_pred_taken = 0;

    //            op        rt     imm       pc            rs            rt_d          pd v  s  br tk mp redir
    vecs[0]  = '{6'b000100, 5'd0, 16'h0003, 32'h00000040, 32'd5,        32'd5,        0, 1, 0, 1, 1, 1, 32'h00000050};
    vecs[1]  = '{6'b000001, 5'd0, 16'hFFFF, 32'h00000100, 32'hFFFFFFFF, 32'd0,        0, 1, 0, 1, 1, 1, 32'h00000100};
    vecs[2]  = '{6'b000001, 5'd0, 16'hFFFF, 32'h00000100, 32'h7FFFFFFF, 32'd0,        0, 1, 0, 1, 0, 0, 32'h00000104};
    vecs[3]  = '{6'b000001, 5'd1, 16'h0010, 32'h00000010, 32'd0,        32'd0,        1, 1, 0, 1, 1, 0, 32'h00000054};
    vecs[4]  = '{6'b000001, 5'd1, 16'h0010, 32'h00000010, 32'h80000000, 32'd0,        1, 1, 0, 1, 0, 1, 32'h00000014};
    vecs[5]  = '{6'b000101, 5'd0, 16'h8000, 32'h00001000, 32'd1,        32'd2,        1, 1, 0, 1, 1, 0, 32'hFFFE1004};
    vecs[6]  = '{6'b000101, 5'd0, 16'h8000, 32'h00001000, 32'd7,        32'd7,        0, 1, 0, 1, 0, 0, 32'h00001004};
    vecs[7]  = '{6'b000000, 5'd0, 16'h0003, 32'h00000200, 32'd0,        32'd0,        1, 1, 0, 0, 0, 1, 32'h00000204};
    vecs[8]  = '{6'b000001, 5'd2, 16'h0003, 32'h00000300, 32'hFFFFFFFF, 32'd0,        0, 1, 0, 0, 0, 0, 32'h00000304};
    vecs[9]  = '{6'b000100, 5'd0, 16'h0003, 32'h00000040, 32'd5,        32'd5,        1, 0, 0, 0, 0, 0, 32'h00000044};
    vecs[10] = '{6'b000100, 5'd0, 16'h0003, 32'h00000040, 32'd5,        32'd5,        0, 1, 1, 1, 1, 0, 32'h00000050};
    vecs[11] = '{6'b000100, 5'd0, 16'h0000, 32'hFFFFFFFC, 32'd9,        32'd9,        1, 1, 0, 1, 1, 0, 32'h00000000};

    // Reset state: prediction forced low while reset is high.
    @(negedge clk); #1;
    chk("pred_in_reset", if_pred_taken, 1'b0);
    reset = 1'b0;

    // Combinational decode/resolve table.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].op, vecs[i].rt, vecs[i].imm, vecs[i].pc, vecs[i].rs_d, vecs[i].rt_d,
            vecs[i].pred, vecs[i].valid, vecs[i].stall);
      chk($sformatf("v%0d_is_branch", i), id_is_branch, vecs[i].e_br);
      chk($sformatf("v%0d_taken", i), id_taken, vecs[i].e_tk);
      chk($sformatf("v%0d_mispredict", i), id_mispredict, vecs[i].e_mp);
      chk($sformatf("v%0d_redirect", i), id_redirect_pc, vecs[i].e_redir);
    end

    // Fresh table: every entry weak-NT.
    do_reset();
    idle();
    for (int i = 0; i < 16; i++) begin
      if_pc = 32'(i * 4); #1;
      chk($sformatf("reset_pred_idx%0d", i), if_pred_taken, 1'b0);
    end
    chk("perf_br_reset", perf_branches, 0);
    chk("perf_mp_reset", perf_mispredicts, 0);

    // BEQ at 0x40 taken; same-cycle lookup sees pre-update value.
    if_pc = 32'h40;
    drive(6'b000100, 5'd0, 16'h0003, 32'h40, 32'd5, 32'd5, 1'b0, 1'b1, 1'b0);
    chk("beq_mp", id_mispredict, 1'b1);
    chk("beq_redir", id_redirect_pc, 32'h50);
    chk("beq_no_bypass", if_pred_taken, 1'b0);
    idle();
    chk("beq_pred_next", if_pred_taken, 1'b1);

    // Saturation at 0x84 (index 1): six taken BNE, then two not-taken.
    if_pc = 32'h84;
    for (int i = 0; i < 6; i++)
      drive(6'b000101, 5'd0, 16'h0001, 32'h84, 32'd1, 32'd2, 1'b1, 1'b1, 1'b0);
    idle();
    chk("sat_pred_taken", if_pred_taken, 1'b1);
    drive(6'b000101, 5'd0, 16'h0001, 32'h84, 32'd3, 32'd3, 1'b1, 1'b1, 1'b0);
    idle();
    chk("sat_nt1_pred", if_pred_taken, 1'b1);
    drive(6'b000101, 5'd0, 16'h0001, 32'h84, 32'd3, 32'd3, 1'b1, 1'b1, 1'b0);
    idle();
    chk("sat_nt2_pred", if_pred_taken, 1'b0);

    // Stalled mispredicting BEQ at 0x88 (index 2).
    if_pc = 32'h88;
    for (int i = 0; i < 3; i++) begin
      drive(6'b000100, 5'd0, 16'h0002, 32'h88, 32'd4, 32'd4, 1'b0, 1'b1, 1'b1);
      chk($sformatf("stall%0d_mp", i), id_mispredict, 1'b0);
      chk($sformatf("stall%0d_pred", i), if_pred_taken, 1'b0);
    end
    drive(6'b000100, 5'd0, 16'h0002, 32'h88, 32'd4, 32'd4, 1'b0, 1'b1, 1'b0);
    chk("unstall_mp", id_mispredict, 1'b1);
    idle();
    chk("after_unstall_mp", id_mispredict, 1'b0);
    chk("after_unstall_pred", if_pred_taken, 1'b1);
    // One not-taken drops a single-updated entry (10) back to 01.
    drive(6'b000100, 5'd0, 16'h0002, 32'h88, 32'd4, 32'd5, 1'b1, 1'b1, 1'b0);
    idle();
    chk("stall_single_update", if_pred_taken, 1'b0);

    // Predicted-taken non-branch at 0x200 (index 0, currently 10).
    if_pc = 32'h200;
    drive(6'b000000, 5'd0, 16'h0000, 32'h200, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    chk("nonbr_mp", id_mispredict, 1'b1);
    chk("nonbr_redir", id_redirect_pc, 32'h204);
    idle();
    chk("nonbr_table_same", if_pred_taken, 1'b1);

    // Performance counters: 4 branches, 1 mispredict.
    do_reset();
    drive(6'b000100, 5'd0, 16'h0001, 32'h0, 32'd1, 32'd1, 1'b1, 1'b1, 1'b0);
    drive(6'b000100, 5'd0, 16'h0001, 32'h4, 32'd1, 32'd1, 1'b1, 1'b1, 1'b0);
    drive(6'b000100, 5'd0, 16'h0001, 32'h8, 32'd1, 32'd1, 1'b1, 1'b1, 1'b0);
    drive(6'b000100, 5'd0, 16'h0001, 32'hC, 32'd1, 32'd1, 1'b0, 1'b1, 1'b0);
    chk("perf_last_mp", id_mispredict, 1'b1);
    idle();
`ifdef BRANCH_PERF_EN
    chk("perf_branches", perf_branches, 4);
    chk("perf_mispredicts", perf_mispredicts, 1);
`else
    chk("perf_branches_off", perf_branches, 0);
    chk("perf_mispredicts_off", perf_mispredicts, 0);
`endif

    // Reset mid-sequence with a taken branch in ID: reset wins.
    @(negedge clk);
    reset = 1'b1;
    id_opcode = 6'b000100; id_pc = 32'h10; id_rs_data = 1; id_rt_data = 1;
    id_pred_taken = 1'b0; id_valid = 1'b1; id_stall = 1'b0;
    #1;
    chk("reset_mp_follows", id_mispredict, 1'b1);
    idle();
    reset = 1'b0;
    #1;
    chk("midreset_perf_br", perf_branches, 0);
    chk("midreset_perf_mp", perf_mispredicts, 0);
    for (int i = 0; i < 16; i++) begin
      if_pc = 32'(i * 4); #1;
      chk($sformatf("midreset_pred_idx%0d", i), if_pred_taken, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch decode, resolve and predict block for the pipelined core. It does three things:
- Decodes the REGIMM and compare-branch opcodes (BLTZ, BGEZ, BEQ, BNE) in ID and resolves the branch there, with no ALU involvement.
- Keeps a direct-mapped table of 2-bit saturating counters that IF reads for a taken/not-taken prediction.
- Raises a one-cycle mispredict with the corrected target, which the hazard unit uses to flush IF/ID and redirect the PC.

## Interface
Parameters:
- WIDTH, 32, PC and register data width
- BHT_DEPTH, 16, prediction table entries; power of two, ≥2
- CNT_W, 32, performance counter width

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- if_pc  input  WIDTH  fetch PC used for lookup
- if_pred_taken  output  1  prediction for if_pc
- id_valid  input  1  ID slot holds a real instruction
- id_stall  input  1  ID held this cycle; no table or counter update
- id_opcode  input  6  instr[31:26]
- id_rt  input  5  instr[20:16]
- id_imm  input  16  instr[15:0]
- id_pc  input  WIDTH  PC of the ID instruction
- id_rs_data  input  WIDTH  forwarded rs value
- id_rt_data  input  WIDTH  forwarded rt value
- id_pred_taken  input  1  prediction carried through IF/ID
- id_is_branch  output  1  decoded branch
- id_taken  output  1  resolved outcome
- id_mispredict  output  1  flush/redirect request
- id_redirect_pc  output  WIDTH  correct next PC
- perf_branches  output  CNT_W  branches retired from ID (BRANCH_PERF_EN only)
- perf_mispredicts  output  CNT_W  mispredicts (BRANCH_PERF_EN only)

## Operation
Decode:
- BLTZ: opcode 000001 with rt 00000.
- BGEZ: opcode 000001 with rt 00001.
- BEQ: opcode 000100.
- BNE: opcode 000101.
- Anything else is not a branch.
- id_is_branch = id_valid & decoded.

Resolve (comparisons are signed, WIDTH bits):
- BLTZ: rs_data[WIDTH-1].
- BGEZ: !rs_data[WIDTH-1].
- BEQ: rs_data == rt_data.
- BNE: rs_data != rt_data.
- id_taken = id_is_branch & condition.

Redirect:
- Target = id_pc + 4 + (sign_extend(id_imm) << 2), computed modulo 2^WIDTH (wraps, no flag).
- id_redirect_pc = id_taken ? target : id_pc + 4.

Mispredict:
- id_mispredict = id_valid & !id_stall & (id_taken != id_pred_taken).
- A non-branch that was predicted taken (table aliasing) also mispredicts; redirect goes to id_pc + 4.

Table:
- Index = pc[IDX+1:2], with IDX = log2(BHT_DEPTH).
- Prediction = counter[1].
- States: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Update only when id_is_branch & !id_stall: taken increments and saturates at 11; not-taken decrements and saturates at 00.
- Non-branches never update the table.

Reset:
- All counters to 01 (weak-NT), so if_pred_taken = 0 after reset.
- Performance counters to 0.
- Reset asserted mid-operation discards any update in that cycle; reset has priority.

## Timing
- if_pred_taken is combinational from if_pc and registered table state: 0-cycle lookup.
- All ID outputs are combinational from the ID inputs: 0-cycle resolve.
- A table update is visible to a lookup from the next cycle onward.
- Same-cycle lookup and update on the same index: the lookup returns the pre-update value; there is no bypass.
- id_mispredict is valid for exactly the cycle the branch is in unstalled ID. A branch stalled for N cycles asserts it only once, on the unstalled cycle.
- Outputs during reset:
  - if_pred_taken = 0.
  - Combinational ID outputs follow their inputs.
  - The hazard unit ignores id_mispredict while reset is high.

## Configuration
- BRANCH_PERF_EN defined:
  - perf_branches increments on each cycle with id_is_branch & !id_stall.
  - perf_mispredicts increments on each cycle with id_mispredict.
  - Both saturate at all-ones; they do not wrap.
  - Both clear on reset.
- BRANCH_PERF_EN undefined:
  - Both ports are tied to 0.
  - No counter flops are present.

## Test plan
- Reset, then BEQ at id_pc=0x40 with rs=rt=5, imm=0x0003, id_pred_taken=0 -> id_taken=1, id_mispredict=1, id_redirect_pc=0x50; next cycle a lookup at if_pc=0x40 gives if_pred_taken=1 (counter 10).
- BLTZ with rs=0xFFFFFFFF, imm=0xFFFF (−1), id_pc=0x100 -> id_taken=1, id_redirect_pc=0x100. Same with rs=0x7FFFFFFF -> id_taken=0, id_redirect_pc=0x104.
- Counter saturation: six taken BNE at one PC -> counter holds 11. Then one not-taken -> 10, prediction still 1. A second not-taken -> 01, prediction 0.
- id_stall=1 for 3 cycles on a mispredicting BEQ -> id_mispredict=0 during the stall, 1 for exactly one cycle after it, and the table updates once.
- Non-branch (opcode 000000) with id_pred_taken=1 at id_pc=0x200 -> id_mispredict=1, id_redirect_pc=0x204, table unchanged.
- With BRANCH_PERF_EN: 4 branches with 1 mispredict -> perf_branches=4, perf_mispredicts=1. Assert reset mid-sequence -> both read 0 and all predictions read 0.
